// File: rtl/alarm_display_driver_if.sv
// Display bus from the alarm block: the 11-bit time value, the enable and the conversion-busy flag.
interface alarm_display_driver_if;
    logic [10:0] display_bus;
    logic        enable;
    logic        busy;

    modport master (output display_bus, output enable, input busy);
    modport slave  (input display_bus, input enable, output busy);
endinterface

// File: rtl/alarm_display_driver.sv
// Captures {AM_PM, HRS, MINS} from the alarm block, converts it to BCD digits and
// scans the four digits onto a single 7-segment driver with an AM/PM LED.
//
// state  | meaning
// IDLE   | waiting for an enabled bus value that differs from the captured one
// CONV   | repeated subtract-10 on the minutes to split tens/units
// UPDATE | write displayed digits and AM/PM LED from the finished conversion
module alarm_display_driver #(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    alarm_display_driver_if.slave   bus_if,
    output logic [6:0]              o_segments,
    output logic [3:0]              o_digit_sel,
    output logic                    o_am_pm_led
);

    localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    D_BLANK  = 4'd10;
    localparam logic [3:0]    D_DASH   = 4'd11;
    localparam logic [6:0]    SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t             r_state, w_next;
    logic               w_capture, w_conv_step;
    logic [10:0]        r_cap;
    logic [5:0]         r_rem;
    logic [2:0]         r_tens;
    logic [3:0][3:0]    r_dig;
    logic               r_am_pm;
    logic [PW-1:0]      r_pre;
    logic [1:0]         r_idx;
    logic [3:0]         r_sel;
    logic [6:0]         r_seg;
    logic [3:0]         w_hrs, w_hrs_units;
    logic               w_hrs_tens, w_invalid;
    logic [6:0]         w_enc;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_conv_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus_if.enable && (bus_if.display_bus != r_cap)) begin
                    w_capture = 1'b1;
                    w_next    = CONV;
                end
            end
            CONV: begin
                if (r_rem >= 6'd10) w_conv_step = 1'b1;
                else                w_next      = UPDATE;
            end
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus_if.busy = (r_state != IDLE);

    assign w_hrs       = r_cap[9:6];
    assign w_invalid   = (w_hrs == 4'd0) || (w_hrs > 4'd12) || (r_cap[5:0] > 6'd59);
    assign w_hrs_tens  = (w_hrs >= 4'd10);
    assign w_hrs_units = w_hrs_tens ? (w_hrs - 4'd10) : w_hrs;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cap   <= 11'h300;
            r_rem   <= 6'd0;
            r_tens  <= 3'd0;
            r_dig   <= {4'd1, 4'd2, 4'd0, 4'd0};
            r_am_pm <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cap  <= bus_if.display_bus;
                r_rem  <= bus_if.display_bus[5:0];
                r_tens <= 3'd0;
            end
            if (w_conv_step) begin
                r_rem  <= r_rem - 6'd10;
                r_tens <= r_tens + 3'd1;
            end
            // Digits only change here, so a reset during CONV never leaves a half-written display
            if (r_state == UPDATE) begin
                if (w_invalid)
                    r_dig <= {4{D_DASH}};
                else
                    r_dig <= {(w_hrs_tens ? 4'd1 : D_BLANK), w_hrs_units, {1'b0, r_tens}, r_rem[3:0]};
                r_am_pm <= r_cap[10];
            end
        end
    end

    always_comb begin
        w_enc = 7'b0000000;
        case (r_dig[r_idx])
            4'd0:    w_enc = 7'b1111110;
            4'd1:    w_enc = 7'b0110000;
            4'd2:    w_enc = 7'b1101101;
            4'd3:    w_enc = 7'b1111001;
            4'd4:    w_enc = 7'b0110011;
            4'd5:    w_enc = 7'b1011011;
            4'd6:    w_enc = 7'b1011111;
            4'd7:    w_enc = 7'b1110000;
            4'd8:    w_enc = 7'b1111111;
            4'd9:    w_enc = 7'b1111011;
            D_DASH:  w_enc = 7'b0000001;
            default: w_enc = 7'b0000000;
        endcase
    end

    // Scan runs freely; ENABLE only gates what reaches the pins
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pre <= '0;
            r_idx <= 2'd3;
            r_sel <= 4'b0000;
            r_seg <= SEG_MASK;
        end else begin
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
                r_idx <= r_idx - 2'd1;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
            r_sel <= bus_if.enable ? (4'b0001 << r_idx) : 4'b0000;
            r_seg <= (bus_if.enable ? w_enc : 7'b0000000) ^ SEG_MASK;
        end
    end

    assign o_segments  = r_seg;
    assign o_digit_sel = r_sel;
    assign o_am_pm_led = r_am_pm;

endmodule

// File: tb/tb_alarm_display_driver.sv
// Scoreboard bench: expected display frames are queued as bus values are driven and
// checked when the DUT finishes each conversion; a second instance covers inverted segments.
module tb_alarm_display_driver;

    localparam int SCAN_DIV = 4;

    typedef struct {
        logic [27:0] segs;
        logic        am_pm;
        int          width;
        bit          frame;
    } exp_t;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    alarm_display_driver_if bus_if ();
    alarm_display_driver_if inv_if ();
    assign inv_if.display_bus = bus_if.display_bus;
    assign inv_if.enable      = bus_if.enable;

    logic [6:0] seg, seg_inv;
    logic [3:0] sel, sel_inv;
    logic       am, am_inv;

    alarm_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
        .CLK(CLK), .RESETN(RESETN), .bus_if(bus_if.slave),
        .o_segments(seg), .o_digit_sel(sel), .o_am_pm_led(am)
    );

    alarm_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut_inv (
        .CLK(CLK), .RESETN(RESETN), .bus_if(inv_if.slave),
        .o_segments(seg_inv), .o_digit_sel(sel_inv), .o_am_pm_led(am_inv)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   busy_seen;
    int   gap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int v);
        case (v)
            0: return 7'b1111110;   1: return 7'b0110000;
            2: return 7'b1101101;   3: return 7'b1111001;
            4: return 7'b0110011;   5: return 7'b1011011;
            6: return 7'b1011111;   7: return 7'b1110000;
            8: return 7'b1111111;   9: return 7'b1111011;
            11: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic exp_t model(input logic [10:0] b, input bit fr);
        exp_t e;
        int   h, m;
        int   d [4];
        h = int'(b[9:6]);
        m = int'(b[5:0]);
        if (h == 0 || h > 12 || m > 59) begin
            d = '{11, 11, 11, 11};
        end else begin
            d[3] = (h >= 10) ? 1 : 10;
            d[2] = h % 10;
            d[1] = m / 10;
            d[0] = m % 10;
        end
        e.segs  = {enc(d[3]), enc(d[2]), enc(d[1]), enc(d[0])};
        e.am_pm = b[10];
        e.width = m / 10 + 2;
        e.frame = fr;
        return e;
    endfunction

    task automatic capture_frame(input logic [27:0] exp, input bit timed, input string tag);
        for (int d = 3; d >= 0; d--) begin
            logic [3:0] oh;
            logic [6:0] e7, inv7;
            int t, n;
            oh   = 4'b0001 << d;
            e7   = exp[d*7 +: 7];
            inv7 = ~e7;
            t = 0;
            while (sel !== oh && t < 4*SCAN_DIV + 4) begin
                @(negedge CLK);
                t++;
            end
            chk({tag, "_sel"}, sel, oh);
            chk({tag, "_seg"}, seg, e7);
            chk({tag, "_seginv"}, seg_inv, inv7);
            if (timed) begin
                n = 0;
                while (sel === oh && n < 2*SCAN_DIV) begin
                    busy_seen |= bus_if.busy;
                    n++;
                    @(negedge CLK);
                end
                chk({tag, "_len"}, n, SCAN_DIV);
            end
        end
    endtask

    task automatic apply(input logic [10:0] b, input bit fr);
        @(negedge CLK);
        bus_if.display_bus = b;
        sb.push_back(model(b, fr));
    endtask

    task automatic expect_update(input bit mid_valid, input logic [10:0] mid_bus,
                                 output int gap_o, input string tag);
        exp_t e;
        int   t, w;
        gap_o = -1;
        chk({tag, "_sb"}, sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        t = 0;
        while (!bus_if.busy && t < 4) begin
            @(negedge CLK);
            t++;
        end
        gap_o = t;
        chk({tag, "_rise"}, bus_if.busy, 1);
        w = 0;
        while (bus_if.busy && w < 20) begin
            w++;
            if (mid_valid && w == 2) begin
                bus_if.display_bus = mid_bus;
                sb.push_back(model(mid_bus, 1'b1));
            end
            @(negedge CLK);
        end
        chk({tag, "_width"}, w, e.width);
        chk({tag, "_am"}, am, e.am_pm);
        chk({tag, "_am_inv"}, am_inv, e.am_pm);
        if (e.frame) begin
            @(negedge CLK);
            capture_frame(e.segs, 1'b0, tag);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t r;
        RESETN             = 1'b0;
        bus_if.enable      = 1'b1;
        bus_if.display_bus = 11'h300;
        #12;
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_sel", sel, 4'b0000);
        chk("rst_seg", seg, 7'h00);
        chk("rst_seg_inv", seg_inv, 7'h7F);
        chk("rst_am", am, 0);
        @(negedge CLK);
        RESETN = 1'b1;

        // reset display 12:00 with slot timing, no conversion
        r = model(11'h300, 1'b1);
        busy_seen = 1'b0;
        capture_frame(r.segs, 1'b1, "t1");
        chk("t1_busy", busy_seen, 0);

        apply({1'b1, 4'd9, 6'd59}, 1'b1);
        expect_update(1'b0, 11'h0, gap, "t2");

        apply({1'b0, 4'd12, 6'd60}, 1'b1);
        expect_update(1'b0, 11'h0, gap, "t3a");
        apply({1'b0, 4'd0, 6'd30}, 1'b1);
        expect_update(1'b0, 11'h0, gap, "t3b");

        // disabled: blanked and no capture until ENABLE returns
        @(negedge CLK);
        bus_if.enable      = 1'b0;
        bus_if.display_bus = {1'b0, 4'd10, 6'd5};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t4_busy", bus_if.busy, 0);
        end
        chk("t4_sel", sel, 4'b0000);
        chk("t4_seg", seg, 7'h00);
        chk("t4_seg_inv", seg_inv, 7'h7F);
        chk("t4_sel_inv", sel_inv, 4'b0000);
        bus_if.enable = 1'b1;
        sb.push_back(model({1'b0, 4'd10, 6'd5}, 1'b1));
        expect_update(1'b0, 11'h0, gap, "t4");
        chk("t4_gap", gap, 1);

        // bus change during conversion is picked up after it completes
        apply({1'b1, 4'd11, 6'd47}, 1'b0);
        expect_update(1'b1, {1'b0, 4'd3, 6'd8}, gap, "t5a");
        expect_update(1'b0, 11'h0, gap, "t5b");
        chk("t5_gap", gap, 1);

        // reset in the middle of a conversion
        @(negedge CLK);
        bus_if.display_bus = {1'b1, 4'd7, 6'd45};
        for (int i = 0; i < 4 && !bus_if.busy; i++) @(negedge CLK);
        chk("t6_rise", bus_if.busy, 1);
        repeat (2) @(negedge CLK);
        RESETN             = 1'b0;
        bus_if.display_bus = 11'h300;
        #1;
        chk("t6_busy", bus_if.busy, 0);
        chk("t6_sel", sel, 4'b0000);
        chk("t6_seg", seg, 7'h00);
        chk("t6_seg_inv", seg_inv, 7'h7F);
        chk("t6_am", am, 0);
        @(negedge CLK);
        RESETN    = 1'b1;
        busy_seen = 1'b0;
        capture_frame(r.segs, 1'b1, "t6");
        chk("t6_nobusy", busy_seen, 0);
        chk("t6_am_after", am, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
